// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and multiplier sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Pipeline-side request/result signals and shared-ALU borrow port of the multiplier.
// master: pipeline + ALU arbiter side; slave: the multiplier sequencer.
interface alu_mul_seq_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
);

  logic                     start;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    product;

  logic                     alu_req;
  logic                     alu_gnt;
  logic [DATA_WIDTH-1:0]    alu_src_a;
  logic [DATA_WIDTH-1:0]    alu_src_b;
  logic [OPCODE_LENGTH-1:0] alu_operation;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport master (
    output start, op_a, op_b, alu_gnt, alu_result,
    input  busy, done, product, alu_req, alu_src_a, alu_src_b, alu_operation
  );

  modport slave (
    input  start, op_a, op_b, alu_gnt, alu_result,
    output busy, done, product, alu_req, alu_src_a, alu_src_b, alu_operation
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier that borrows the shared integer ALU (low-half MUL).
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input logic         clk,
  input logic         reset,
  alu_mul_seq_if.slave bus
);

  localparam int unsigned           CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(DATA_WIDTH - 1);

  mul_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] product_q;
  logic                  early_exit;

`ifdef MUL_EARLY_EXIT_EN
  assign early_exit = (mplier_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    acc_d             = acc_q;
    mcand_d           = mcand_q;
    mplier_d          = mplier_q;
    cnt_d             = cnt_q;
    bus.alu_req       = 1'b0;
    bus.alu_src_a     = '0;
    bus.alu_src_b     = '0;
    bus.alu_operation = OPCODE_LENGTH'(ALU_AND);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          cnt_d    = '0;
          state_d  = ADD;
        end
      end
      ADD: begin
        if (early_exit) begin
          state_d = DONE;
        end else if (mplier_q[0]) begin
          bus.alu_req       = 1'b1;
          bus.alu_operation = OPCODE_LENGTH'(ALU_ADD);
          bus.alu_src_a     = acc_q;
          bus.alu_src_b     = mcand_q;
          if (bus.alu_gnt) begin
            acc_d   = bus.alu_result;
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.alu_req       = 1'b1;
        bus.alu_operation = OPCODE_LENGTH'(ALU_SLL);
        bus.alu_src_a     = mcand_q;
        bus.alu_src_b     = DATA_WIDTH'(1);
        if (bus.alu_gnt) begin
          mcand_d  = bus.alu_result;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          state_d  = (cnt_q == CntLast) ? DONE : ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      // Capture on the edge entering DONE so product is already valid while done is high.
      if (state_d == DONE && state_q != DONE) begin
        product_q <= acc_q;
      end
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared-ALU model and a driven grant.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  alu_mul_seq_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_mul_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared integer ALU, combinational.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_operation)
      ALU_AND: bus.alu_result = bus.alu_src_a & bus.alu_src_b;
      ALU_OR:  bus.alu_result = bus.alu_src_a | bus.alu_src_b;
      ALU_ADD: bus.alu_result = bus.alu_src_a + bus.alu_src_b;
      ALU_SUB: bus.alu_result = bus.alu_src_a - bus.alu_src_b;
      ALU_SLL: bus.alu_result = bus.alu_src_a << bus.alu_src_b[4:0];
      ALU_SRL: bus.alu_result = bus.alu_src_a >> bus.alu_src_b[4:0];
      default: bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Clock edges from the accepting edge until done is observed, with grant always given.
  function automatic int exp_edges(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int top = -1;
    for (int i = 0; i < 32; i++) if (b[i]) top = i;
    if (top < 0)   return 1;
    if (top == 31) return 64;
    return 2 * (top + 1) + 1;
`else
    return 64;
`endif
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit tog,
                         input bit inject, output logic [31:0] prod, output int edges,
                         output int denied, output int stall_bad, output bit req_seen,
                         output logic busy_after, output logic done_after);
    logic [31:0] sa, sb;
    logic [3:0]  sop;
    bit          pend;
    sa = '0; sb = '0; sop = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.alu_gnt = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    edges = 0; denied = 0; stall_bad = 0; req_seen = 1'b0; pend = 1'b0;
    while (!bus.done && edges < 400) begin
      if (pend && (bus.alu_src_a !== sa || bus.alu_src_b !== sb || bus.alu_operation !== sop))
        stall_bad++;
      pend = 1'b0;
      if (tog) bus.alu_gnt = ~bus.alu_gnt;
      if (inject && edges == 2) begin
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.alu_req) req_seen = 1'b1;
      if (bus.alu_req && !bus.alu_gnt) begin
        denied++;
        pend = 1'b1;
        sa = bus.alu_src_a; sb = bus.alu_src_b; sop = bus.alu_operation;
      end
      @(negedge clk);
      edges++;
    end
    bus.start   = 1'b0;
    bus.alu_gnt = 1'b1;
    prod = bus.product;
    @(negedge clk);
    busy_after = bus.busy;
    done_after = bus.done;
  endtask

  initial begin
    logic [31:0] prod;
    int          edges, denied, stall_bad;
    bit          req_seen, found;
    logic        busy_after, done_after;

    reset = 1'b1;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.alu_gnt = 1'b1;
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_req", 32'(bus.alu_req), 32'd0);
    check("reset_product", bus.product, 32'd0);
    check("reset_op", 32'(bus.alu_operation), 32'(ALU_AND));
    @(negedge clk);
    reset = 1'b0;

    run_mul(32'd3, 32'd5, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("3x5_product", prod, 32'd15);
    check("3x5_latency", 32'(edges), 32'(exp_edges(32'd5)));
    check("3x5_busy_after", 32'(busy_after), 32'd0);
    check("3x5_done_pulse", 32'(done_after), 32'd0);
    check("idle_op_quiet", 32'(bus.alu_operation), 32'(ALU_AND));

    run_mul(32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("neg7x3_product", prod, 32'hFFFF_FFEB);
    check("neg7x3_latency", 32'(edges), 32'(exp_edges(32'd3)));

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, prod, edges, denied, stall_bad,
            req_seen, busy_after, done_after);
    check("m1xm1_product", prod, 32'h0000_0001);
    check("m1xm1_latency", 32'(edges), 32'(exp_edges(32'hFFFF_FFFF)));

    run_mul(32'd1234, 32'd5678, 1'b1, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("toggle_product", prod, 32'd7006652);
    check("toggle_latency", 32'(edges), 32'(exp_edges(32'd5678) + denied));
    check("toggle_denied_seen", 32'(denied > 0), 32'd1);
    check("toggle_stall_hold", 32'(stall_bad), 32'd0);

    run_mul(32'd3, 32'd5, 1'b0, 1'b1, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("ignore_start_product", prod, 32'd15);
    check("ignore_start_latency", 32'(edges), 32'(exp_edges(32'd5)));
    check("ignore_start_idle", 32'(busy_after), 32'd0);

    run_mul(32'd9, 32'd9, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("restart_product", prod, 32'd81);

    // Asynchronous reset while the ALU is performing a shift.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.alu_operation == ALU_SLL) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_shift", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    check("async_req", 32'(bus.alu_req), 32'd0);
    check("async_product", bus.product, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mul(32'd6, 32'd7, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("after_reset_product", prod, 32'd42);

    run_mul(32'h0000_1234, 32'd0, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("b0_product", prod, 32'd0);
    check("b0_latency", 32'(edges), 32'(exp_edges(32'd0)));
`ifdef MUL_EARLY_EXIT_EN
    check("b0_no_req", 32'(req_seen), 32'd0);
`endif

    run_mul(32'h0000_0055, 32'd1, 1'b0, 1'b0, prod, edges, denied, stall_bad, req_seen,
            busy_after, done_after);
    check("b1_product", prod, 32'h0000_0055);
    check("b1_latency", 32'(edges), 32'(exp_edges(32'd1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-and-add multiplier sequencer for the RISC-V pipeline.
- Borrows the shared integer ALU to compute the low DATA_WIDTH bits of op_a*op_b (MUL semantics).
- Drives the ALU's SrcA/SrcB/Operation through a request/grant port; the pipeline EX stage owns the ALU when grant is low.
- Sits beside EX; the pipeline holds the MUL instruction until done.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU operation code width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op_a  input  DATA_WIDTH  multiplicand, latched on accepted start.
- op_b  input  DATA_WIDTH  multiplier, latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product valid.
- product  output  DATA_WIDTH  low DATA_WIDTH bits of op_a*op_b; holds until next completion.
- alu_req  output  1  ALU use requested this cycle.
- alu_gnt  input  1  ALU granted this cycle (combinational from arbiter).
- alu_src_a  output  DATA_WIDTH  to ALU SrcA.
- alu_src_b  output  DATA_WIDTH  to ALU SrcB.
- alu_operation  output  OPCODE_LENGTH  to ALU Operation.
- alu_result  input  DATA_WIDTH  from ALU ALUResult, same cycle.

Behaviour:
- Reset (async, any state): state=IDLE; acc, mcand, mplier, cnt, product=0; busy=0, done=0, alu_req=0; ALU outputs 0 with operation AND (4'b0000).
- IDLE: start=1 latches acc=0, mcand=op_a, mplier=op_b, cnt=0, then moves to ADD.
- ADD, mplier[0]=1: alu_req=1, operation ADD (4'b0010), src_a=acc, src_b=mcand. On alu_gnt: acc<=alu_result, go SHIFT. Without grant: stall in ADD with all registers unchanged.
- ADD, mplier[0]=0: alu_req=0; go SHIFT next cycle.
- SHIFT: alu_req=1, operation SLL (4'b0100), src_a=mcand, src_b=1. On alu_gnt: mcand<=alu_result, mplier<=mplier>>1 (logical), cnt<=cnt+1. Then go DONE if cnt==DATA_WIDTH-1, else ADD. Without grant: stall.
- DONE: done=1 for exactly one cycle; product<=acc (registered on the DONE entry edge, so product is valid while done=1); next state IDLE.
- Latency with alu_gnt tied 1: start sampled at edge k, done high during cycle k+65 (2*DATA_WIDTH+1). Each denied-grant cycle adds one.
- Arithmetic: wrap modulo 2^DATA_WIDTH. The result is correct for signed and unsigned operands.
- start while busy: ignored, no queueing. Operand changes after acceptance: no effect.
- alu_req=0 states: ALU outputs forced to 0 / AND so the mux stays quiet.
- Counter width: $clog2(DATA_WIDTH).

Optional Feature:
- MUL_EARLY_EXIT_EN defined: in ADD, if mplier==0, go directly to DONE without requesting the ALU.
  - op_b=0: done at k+2.
  - op_b=1: done at k+4.
- MUL_EARLY_EXIT_EN undefined: always 32 iterations; fixed latency 2*DATA_WIDTH+1.
- Result is identical in both cases.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0011, ALU_SLL=4'b0100, ALU_SRL=4'b0101, ALU_SRA=4'b0111.
  - typedef enum logic [1:0] mul_state_t {IDLE, ADD, SHIFT, DONE}.
- No sub-module: a single FSM plus datapath registers. The ALU itself is instantiated outside and muxed by the arbiter.

Test Plan:
- gnt=1, op_a=3, op_b=5, start pulse -> done exactly 65 cycles later, product=15, busy low the cycle after done.
- gnt=1, op_a=0xFFFFFFF9 (-7), op_b=3 -> product=0xFFFFFFEB; op_a=op_b=0xFFFFFFFF -> product=0x00000001.
- alu_gnt toggling 1/0 each cycle, op_a=1234, op_b=5678 -> product=7006652; latency equals 65 plus denied-grant cycles while alu_req=1; registers unchanged on denied cycles.
- start reasserted with op_a=9 mid-operation of 3*5 -> ignored, product=15; a new start after done is accepted.
- reset asserted asynchronously mid-SHIFT -> busy, done, alu_req, product go 0 immediately (no clock edge needed); next start 6*7 -> 42.
- MUL_EARLY_EXIT_EN defined, op_b=0 -> done at k+2, product=0, alu_req never high; undefined -> done at k+65, product=0.
